// File: rtl/cmp_result_monitor_if.sv
// Sample/result bundle between a comparator-result source and cmp_result_monitor.
// The source drives the qualified comparator flags and soft clear; the monitor returns its tallies and streak status.
interface cmp_result_monitor_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             agb;
    logic             alb;
    logic             aeb;
    logic             clr;
    logic [CNT_W-1:0] gt_cnt;
    logic [CNT_W-1:0] lt_cnt;
    logic [CNT_W-1:0] eq_cnt;
    logic [1:0]       last_code;
    logic             sample_done;
    logic [3:0]       run_len;
    logic             match_lock;
    logic             lock_lost;
    logic [CNT_W-1:0] err_cnt;
    logic             err_sticky;

    modport master (
        output in_valid, agb, alb, aeb, clr,
        input  gt_cnt, lt_cnt, eq_cnt, last_code, sample_done,
        input  run_len, match_lock, lock_lost, err_cnt, err_sticky
    );

    modport slave (
        input  in_valid, agb, alb, aeb, clr,
        output gt_cnt, lt_cnt, eq_cnt, last_code, sample_done,
        output run_len, match_lock, lock_lost, err_cnt, err_sticky
    );
endinterface

// File: rtl/cmp_result_monitor.sv
// Tallies one-hot comparator results, tracks runs of consecutive equal samples, and locks after STREAK_LEN of them.
// Define CMP_MON_ERR_CHECK_EN to count illegal flag combinations into err_cnt/err_sticky.
module cmp_result_monitor #(
    parameter int CNT_W      = 8,
    parameter int STREAK_LEN = 4
) (
    input logic                 clk,
    input logic                 reset,
    cmp_result_monitor_if.slave bus
);

    typedef enum logic [1:0] {IDLE, TRACK, LOCK} state_t;

    localparam logic [3:0]       STREAK  = 4'(STREAK_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t     state;
    state_t     state_nxt;
    logic       accept;
    logic       legal;
    logic       is_eq;
    logic [3:0] run_inc;
    logic [3:0] run_nxt;
    logic       lost_nxt;

    // Odd parity minus the all-ones case leaves exactly the one-hot patterns.
    assign accept  = bus.in_valid & ~bus.clr;
    assign legal   = (bus.agb ^ bus.alb ^ bus.aeb) & ~(bus.agb & bus.alb & bus.aeb);
    assign is_eq   = legal & bus.aeb;
    assign run_inc = (bus.run_len == 4'hF) ? 4'hF : bus.run_len + 4'd1;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.clr) begin
            state_nxt = IDLE;
        end else if (bus.in_valid) begin
            case (state)
                IDLE:    if (is_eq) state_nxt = (STREAK == 4'd1) ? LOCK : TRACK;
                TRACK:   if (!is_eq) state_nxt = IDLE;
                         else if (run_inc >= STREAK) state_nxt = LOCK;
                LOCK:    if (!is_eq) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Any non-eq sample (including illegal ones) breaks the run; losing it from LOCK is reported once.
    always_comb begin
        run_nxt  = bus.run_len;
        lost_nxt = 1'b0;
        if (bus.clr) begin
            run_nxt = '0;
        end else if (bus.in_valid) begin
            if (is_eq) begin
                run_nxt = (state == IDLE) ? 4'd1 : run_inc;
            end else begin
                run_nxt  = '0;
                lost_nxt = (state == LOCK);
            end
        end
    end

    assign bus.match_lock = (state == LOCK);

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.gt_cnt      <= '0;
            bus.lt_cnt      <= '0;
            bus.eq_cnt      <= '0;
            bus.last_code   <= 2'b00;
            bus.sample_done <= 1'b0;
            bus.run_len     <= '0;
            bus.lock_lost   <= 1'b0;
        end else if (bus.clr) begin
            bus.gt_cnt      <= '0;
            bus.lt_cnt      <= '0;
            bus.eq_cnt      <= '0;
            bus.last_code   <= 2'b00;
            bus.sample_done <= 1'b0;
            bus.run_len     <= '0;
            bus.lock_lost   <= 1'b0;
        end else begin
            bus.sample_done <= accept;
            bus.run_len     <= run_nxt;
            bus.lock_lost   <= lost_nxt;
            if (accept && legal) begin
                if (bus.agb) begin
                    if (bus.gt_cnt != CNT_MAX) bus.gt_cnt <= bus.gt_cnt + 1'b1;
                    bus.last_code <= 2'b10;
                end else if (bus.alb) begin
                    if (bus.lt_cnt != CNT_MAX) bus.lt_cnt <= bus.lt_cnt + 1'b1;
                    bus.last_code <= 2'b01;
                end else begin
                    if (bus.eq_cnt != CNT_MAX) bus.eq_cnt <= bus.eq_cnt + 1'b1;
                    bus.last_code <= 2'b11;
                end
            end
        end
    end

`ifdef CMP_MON_ERR_CHECK_EN
    // Soft clear zeroes the error tally but the sticky flag survives until a hard reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.err_cnt    <= '0;
            bus.err_sticky <= 1'b0;
        end else if (bus.clr) begin
            bus.err_cnt    <= '0;
        end else if (accept && !legal) begin
            if (bus.err_cnt != CNT_MAX) bus.err_cnt <= bus.err_cnt + 1'b1;
            bus.err_sticky <= 1'b1;
        end
    end
`else
    assign bus.err_cnt    = '0;
    assign bus.err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_cmp_result_monitor.sv
// Scoreboard bench for cmp_result_monitor (CNT_W=4, STREAK_LEN=4); works with or without CMP_MON_ERR_CHECK_EN.
module tb_cmp_result_monitor;
    localparam int CNT_W      = 4;
    localparam int STREAK_LEN = 4;
`ifdef CMP_MON_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        logic [CNT_W-1:0] gt, lt, eq, err;
        logic [1:0]       code;
        logic [3:0]       run;
        logic             done, lock, lost, sticky;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    exp_t exp_q[$];
    exp_t m;
    exp_t e;
    int   mst;
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    cmp_result_monitor_if #(.CNT_W(CNT_W)) bus ();

    cmp_result_monitor #(.CNT_W(CNT_W), .STREAK_LEN(STREAK_LEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Drive one clock of stimulus, advance the reference model and queue its expectation.
    task automatic cycle(input logic rst, input logic v, input logic a, input logic l, input logic q, input logic cl);
        reset = rst; bus.in_valid = v; bus.agb = a; bus.alb = l; bus.aeb = q; bus.clr = cl;
        m.done = 1'b0;
        m.lost = 1'b0;
        if (rst) begin
            m = '{default: '0};
            mst = 0;
        end else if (cl) begin
            m.gt = '0; m.lt = '0; m.eq = '0; m.err = '0; m.code = 2'b00; m.run = '0;
            mst = 0;
        end else if (v) begin
            m.done = 1'b1;
            if (int'(a) + int'(l) + int'(q) == 1) begin
                if (a) begin m.gt = sat(m.gt); m.code = 2'b10; end
                if (l) begin m.lt = sat(m.lt); m.code = 2'b01; end
                if (q) begin m.eq = sat(m.eq); m.code = 2'b11; end
            end else if (ERR_EN) begin
                m.err = sat(m.err);
                m.sticky = 1'b1;
            end
            if (int'(a) + int'(l) + int'(q) == 1 && q) begin
                if (mst == 0) begin
                    m.run = 4'd1;
                    mst = (STREAK_LEN == 1) ? 2 : 1;
                end else begin
                    if (m.run != 4'hF) m.run = m.run + 4'd1;
                    if (mst == 1 && int'(m.run) >= STREAK_LEN) mst = 2;
                end
            end else begin
                if (mst == 2) m.lost = 1'b1;
                m.run = '0;
                mst = 0;
            end
        end
        m.lock = (mst == 2);
        exp_q.push_back(m);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; bus.in_valid = 1'b0; bus.clr = 1'b0;
    endtask

    task automatic test_reset;
        cycle(1, 1, 0, 0, 1, 1); e = exp_q.pop_front();
        cycle(1, 0, 0, 0, 0, 0); e = exp_q.pop_front();
        compared++; if (bus.gt_cnt !== e.gt) begin mismatched++; $display("[TB] FAIL reset gt_cnt got=%0d exp=%0d", bus.gt_cnt, e.gt); end
        compared++; if (bus.lt_cnt !== e.lt) begin mismatched++; $display("[TB] FAIL reset lt_cnt got=%0d exp=%0d", bus.lt_cnt, e.lt); end
        compared++; if (bus.eq_cnt !== e.eq) begin mismatched++; $display("[TB] FAIL reset eq_cnt got=%0d exp=%0d", bus.eq_cnt, e.eq); end
        compared++; if (bus.last_code !== e.code) begin mismatched++; $display("[TB] FAIL reset last_code got=%b exp=%b", bus.last_code, e.code); end
        compared++; if (bus.run_len !== e.run) begin mismatched++; $display("[TB] FAIL reset run_len got=%0d exp=%0d", bus.run_len, e.run); end
        compared++; if (bus.sample_done !== e.done) begin mismatched++; $display("[TB] FAIL reset sample_done got=%b exp=%b", bus.sample_done, e.done); end
        compared++; if (bus.match_lock !== e.lock) begin mismatched++; $display("[TB] FAIL reset match_lock got=%b exp=%b", bus.match_lock, e.lock); end
        compared++; if (bus.lock_lost !== e.lost) begin mismatched++; $display("[TB] FAIL reset lock_lost got=%b exp=%b", bus.lock_lost, e.lost); end
        compared++; if (bus.err_cnt !== e.err) begin mismatched++; $display("[TB] FAIL reset err_cnt got=%0d exp=%0d", bus.err_cnt, e.err); end
        compared++; if (bus.err_sticky !== e.sticky) begin mismatched++; $display("[TB] FAIL reset err_sticky got=%b exp=%b", bus.err_sticky, e.sticky); end
    endtask

    task automatic test_legal_sequence;
        int pulses;
        pulses = 0;
        cycle(0, 1, 0, 1, 0, 0); e = exp_q.pop_front(); if (bus.sample_done === 1'b1) pulses++;
        compared++; if (bus.last_code !== e.code) begin mismatched++; $display("[TB] FAIL seq_lt last_code got=%b exp=%b", bus.last_code, e.code); end
        cycle(0, 1, 1, 0, 0, 0); e = exp_q.pop_front(); if (bus.sample_done === 1'b1) pulses++;
        cycle(0, 1, 0, 0, 1, 0); e = exp_q.pop_front(); if (bus.sample_done === 1'b1) pulses++;
        compared++; if (bus.lt_cnt !== e.lt) begin mismatched++; $display("[TB] FAIL seq lt_cnt got=%0d exp=%0d", bus.lt_cnt, e.lt); end
        compared++; if (bus.gt_cnt !== e.gt) begin mismatched++; $display("[TB] FAIL seq gt_cnt got=%0d exp=%0d", bus.gt_cnt, e.gt); end
        compared++; if (bus.eq_cnt !== e.eq) begin mismatched++; $display("[TB] FAIL seq eq_cnt got=%0d exp=%0d", bus.eq_cnt, e.eq); end
        compared++; if (bus.last_code !== e.code) begin mismatched++; $display("[TB] FAIL seq last_code got=%b exp=%b", bus.last_code, e.code); end
        compared++; if (pulses !== 3) begin mismatched++; $display("[TB] FAIL seq done_pulses got=%0d exp=3", pulses); end
    endtask

    task automatic test_hold;
        cycle(0, 0, 1, 0, 0, 0); e = exp_q.pop_front();
        compared++; if (bus.sample_done !== e.done) begin mismatched++; $display("[TB] FAIL hold sample_done got=%b exp=%b", bus.sample_done, e.done); end
        compared++; if (bus.gt_cnt !== e.gt) begin mismatched++; $display("[TB] FAIL hold gt_cnt got=%0d exp=%0d", bus.gt_cnt, e.gt); end
        compared++; if (bus.run_len !== e.run) begin mismatched++; $display("[TB] FAIL hold run_len got=%0d exp=%0d", bus.run_len, e.run); end
    endtask

    task automatic test_streak_lock;
        cycle(1, 0, 0, 0, 0, 0); e = exp_q.pop_front();
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 0, 0, 1, 0); e = exp_q.pop_front();
            compared++; if (bus.run_len !== e.run) begin mismatched++; $display("[TB] FAIL streak%0d run_len got=%0d exp=%0d", i, bus.run_len, e.run); end
            compared++; if (bus.match_lock !== e.lock) begin mismatched++; $display("[TB] FAIL streak%0d match_lock got=%b exp=%b", i, bus.match_lock, e.lock); end
        end
        cycle(0, 1, 1, 0, 0, 0); e = exp_q.pop_front();
        compared++; if (bus.match_lock !== e.lock) begin mismatched++; $display("[TB] FAIL break match_lock got=%b exp=%b", bus.match_lock, e.lock); end
        compared++; if (bus.lock_lost !== e.lost) begin mismatched++; $display("[TB] FAIL break lock_lost got=%b exp=%b", bus.lock_lost, e.lost); end
        compared++; if (bus.run_len !== e.run) begin mismatched++; $display("[TB] FAIL break run_len got=%0d exp=%0d", bus.run_len, e.run); end
        cycle(0, 0, 0, 0, 0, 0); e = exp_q.pop_front();
        compared++; if (bus.lock_lost !== e.lost) begin mismatched++; $display("[TB] FAIL break lock_lost_pulse got=%b exp=%b", bus.lock_lost, e.lost); end
    endtask

    task automatic test_illegal;
        cycle(1, 0, 0, 0, 0, 0); e = exp_q.pop_front();
        cycle(0, 1, 1, 0, 1, 0); e = exp_q.pop_front();
        compared++; if (bus.err_cnt !== e.err) begin mismatched++; $display("[TB] FAIL illegal err_cnt got=%0d exp=%0d", bus.err_cnt, e.err); end
        compared++; if (bus.err_sticky !== e.sticky) begin mismatched++; $display("[TB] FAIL illegal err_sticky got=%b exp=%b", bus.err_sticky, e.sticky); end
        compared++; if (bus.sample_done !== e.done) begin mismatched++; $display("[TB] FAIL illegal sample_done got=%b exp=%b", bus.sample_done, e.done); end
        compared++; if (bus.gt_cnt !== e.gt || bus.eq_cnt !== e.eq) begin mismatched++; $display("[TB] FAIL illegal counts got=%0d/%0d exp=%0d/%0d", bus.gt_cnt, bus.eq_cnt, e.gt, e.eq); end
        compared++; if (bus.last_code !== e.code) begin mismatched++; $display("[TB] FAIL illegal last_code got=%b exp=%b", bus.last_code, e.code); end
        cycle(0, 1, 0, 0, 0, 0); e = exp_q.pop_front();
        compared++; if (bus.err_cnt !== e.err) begin mismatched++; $display("[TB] FAIL none_set err_cnt got=%0d exp=%0d", bus.err_cnt, e.err); end
    endtask

    task automatic test_clr_collision;
        cycle(0, 1, 1, 1, 1, 0); e = exp_q.pop_front();
        cycle(0, 1, 0, 0, 1, 0); e = exp_q.pop_front();
        cycle(0, 1, 0, 0, 1, 0); e = exp_q.pop_front();
        compared++; if (bus.run_len !== e.run) begin mismatched++; $display("[TB] FAIL pre_clr run_len got=%0d exp=%0d", bus.run_len, e.run); end
        cycle(0, 1, 0, 0, 1, 1); e = exp_q.pop_front();
        compared++; if (bus.eq_cnt !== e.eq || bus.gt_cnt !== e.gt || bus.lt_cnt !== e.lt) begin mismatched++; $display("[TB] FAIL clr counts got=%0d/%0d/%0d exp=%0d/%0d/%0d", bus.eq_cnt, bus.gt_cnt, bus.lt_cnt, e.eq, e.gt, e.lt); end
        compared++; if (bus.run_len !== e.run) begin mismatched++; $display("[TB] FAIL clr run_len got=%0d exp=%0d", bus.run_len, e.run); end
        compared++; if (bus.sample_done !== e.done) begin mismatched++; $display("[TB] FAIL clr sample_done got=%b exp=%b", bus.sample_done, e.done); end
        compared++; if (bus.last_code !== e.code) begin mismatched++; $display("[TB] FAIL clr last_code got=%b exp=%b", bus.last_code, e.code); end
        compared++; if (bus.err_sticky !== e.sticky) begin mismatched++; $display("[TB] FAIL clr err_sticky got=%b exp=%b", bus.err_sticky, e.sticky); end
        compared++; if (bus.err_cnt !== e.err) begin mismatched++; $display("[TB] FAIL clr err_cnt got=%0d exp=%0d", bus.err_cnt, e.err); end
        cycle(0, 1, 0, 0, 1, 0); e = exp_q.pop_front();
        compared++; if (bus.run_len !== e.run || bus.match_lock !== e.lock) begin mismatched++; $display("[TB] FAIL post_clr run_len/lock got=%0d/%b exp=%0d/%b", bus.run_len, bus.match_lock, e.run, e.lock); end
    endtask

    task automatic test_saturation;
        cycle(1, 0, 0, 0, 0, 0); e = exp_q.pop_front();
        for (int i = 1; i <= 20; i++) begin
            cycle(0, 1, 1, 0, 0, 0); e = exp_q.pop_front();
            compared++; if (bus.gt_cnt !== e.gt) begin mismatched++; $display("[TB] FAIL sat%0d gt_cnt got=%0d exp=%0d", i, bus.gt_cnt, e.gt); end
        end
        compared++; if (bus.gt_cnt !== 4'd15) begin mismatched++; $display("[TB] FAIL sat_final gt_cnt got=%0d exp=15", bus.gt_cnt); end
    endtask

    task automatic test_reset_in_lock;
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 0, 0, 1, 0); e = exp_q.pop_front();
        end
        compared++; if (bus.match_lock !== e.lock) begin mismatched++; $display("[TB] FAIL pre_rst match_lock got=%b exp=%b", bus.match_lock, e.lock); end
        cycle(1, 1, 1, 0, 0, 0); e = exp_q.pop_front();
        compared++; if (bus.lock_lost !== e.lost) begin mismatched++; $display("[TB] FAIL rst_lock lock_lost got=%b exp=%b", bus.lock_lost, e.lost); end
        compared++; if (bus.match_lock !== e.lock) begin mismatched++; $display("[TB] FAIL rst_lock match_lock got=%b exp=%b", bus.match_lock, e.lock); end
        compared++; if (bus.run_len !== e.run || bus.eq_cnt !== e.eq || bus.gt_cnt !== e.gt) begin mismatched++; $display("[TB] FAIL rst_lock run/eq/gt got=%0d/%0d/%0d exp=%0d/%0d/%0d", bus.run_len, bus.eq_cnt, bus.gt_cnt, e.run, e.eq, e.gt); end
        compared++; if (bus.sample_done !== e.done || bus.last_code !== e.code) begin mismatched++; $display("[TB] FAIL rst_lock done/code got=%b/%b exp=%b/%b", bus.sample_done, bus.last_code, e.done, e.code); end
        cycle(0, 0, 0, 0, 0, 0); e = exp_q.pop_front();
        compared++; if (bus.lock_lost !== e.lost) begin mismatched++; $display("[TB] FAIL post_rst lock_lost got=%b exp=%b", bus.lock_lost, e.lost); end
    endtask

    initial begin
        reset = 1'b1; bus.in_valid = 1'b0; bus.agb = 1'b0; bus.alb = 1'b0; bus.aeb = 1'b0; bus.clr = 1'b0;
        m = '{default: '0};
        mst = 0;
        @(negedge clk);
        test_reset();
        test_legal_sequence();
        test_hold();
        test_streak_lock();
        test_illegal();
        test_clr_collision();
        test_saturation();
        test_reset_in_lock();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/cmp_result_monitor.md
CMP_RESULT_MONITOR -- requirements
Module: cmp_result_monitor

Interface
REQ-001 SHALL provide parameter CNT_W, default 8, width of each result counter.
REQ-002 SHALL provide parameter STREAK_LEN, default 4, number of consecutive equal samples (1..15) needed to assert match_lock.
REQ-003 SHALL provide port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port in_valid  input  1  qualifies agb/alb/aeb for sampling this cycle.
REQ-006 SHALL provide ports agb, alb, aeb  input  1 each  comparator result flags from the upstream 4-bit comparator.
REQ-007 SHALL provide port clr  input  1  synchronous soft clear of counters and streak state.
REQ-008 SHALL provide ports gt_cnt, lt_cnt, eq_cnt  output  CNT_W each  saturating tallies of legal samples.
REQ-009 SHALL provide port last_code  output  2  last legal result: 00 none, 01 lt, 10 gt, 11 eq.
REQ-010 SHALL provide port sample_done  output  1  one-cycle pulse per accepted sample.
REQ-011 SHALL provide port run_len  output  4  current consecutive-equal count, saturating at 15.
REQ-012 SHALL provide ports match_lock  output  1, and lock_lost  output  1 (one-cycle pulse).
REQ-013 SHALL provide ports err_cnt  output  CNT_W, and err_sticky  output  1.

Function
REQ-014 SHALL accept a sample only on a rising edge with in_valid=1 and clr=0; with in_valid=0, all state holds.
REQ-015 SHALL classify a sample as legal only when exactly one of agb/alb/aeb is 1; all other combinations are illegal.
REQ-016 SHALL register all outputs: counts, last_code, run_len, and flags reflect a sample on the cycle after it is accepted (latency 1).
REQ-017 SHALL assert sample_done for exactly one cycle for each accepted sample, legal or illegal.
REQ-018 SHALL increment the counter matching a legal sample, saturating at 2^CNT_W-1 with no wrap.
REQ-019 SHALL update last_code only on legal samples.
REQ-020 SHALL implement a streak FSM with states IDLE, TRACK, and LOCK.
REQ-021 In IDLE, an eq sample SHALL set run_len=1 and move to LOCK if STREAK_LEN=1, otherwise to TRACK; any other sample SHALL stay in IDLE.
REQ-022 In TRACK, an eq sample SHALL increment run_len and move to LOCK when run_len reaches STREAK_LEN; any non-eq sample (gt, lt, or illegal) SHALL clear run_len and return to IDLE.
REQ-023 In LOCK, match_lock SHALL be 1; an eq sample SHALL increment run_len (saturating at 15) and stay in LOCK; a non-eq sample SHALL clear run_len, return to IDLE, drop match_lock, and pulse lock_lost for one cycle.
REQ-024 SHALL give clr priority over a same-cycle sample: the sample is discarded, no sample_done is produced, all counters and run_len go to 0, last_code goes to 00, and the FSM goes to IDLE.
REQ-025 clr SHALL NOT clear err_sticky; only reset does.

Reset
REQ-026 On reset=1 at a clock edge, the block SHALL set all counts=0, last_code=00, run_len=0, sample_done=0, match_lock=0, lock_lost=0, err_sticky=0, and FSM=IDLE; reset SHALL override clr and in_valid.
REQ-027 Asserting reset mid-streak or while in LOCK SHALL NOT pulse lock_lost.

Configuration
REQ-028 SHALL support macro CMP_MON_ERR_CHECK_EN.
REQ-029 With CMP_MON_ERR_CHECK_EN defined, each illegal sample SHALL increment err_cnt (saturating) and set err_sticky.
REQ-030 Without CMP_MON_ERR_CHECK_EN, err_cnt and err_sticky SHALL be constant 0. Illegal samples SHALL still pulse sample_done and break streaks, but SHALL otherwise be ignored.

Verification
REQ-031 The bench SHALL check legal sequencing: after reset, in_valid=1 for lt, gt, eq -> lt_cnt=1, gt_cnt=1, eq_cnt=1, last_code=11, three sample_done pulses.
REQ-032 The bench SHALL check streak lock: 4 consecutive eq samples (STREAK_LEN=4) -> match_lock=1 the cycle after the 4th sample, run_len=4; a following gt sample -> match_lock=0, lock_lost pulses once, run_len=0.
REQ-033 The bench SHALL check saturation: with CNT_W=4, 20 gt samples -> gt_cnt=15 and no wrap.
REQ-034 The bench SHALL check illegal input: agb=1, aeb=1 with in_valid=1 -> with macro, err_cnt=1 and err_sticky=1; without macro, both stay 0; in both builds counts are unchanged and sample_done pulses.
REQ-035 The bench SHALL check clr collision: clr=1 together with a valid eq sample while in TRACK (run_len=2) -> all counts=0, run_len=0, FSM in IDLE, no sample_done pulse, err_sticky retained.
REQ-036 The bench SHALL check reset in LOCK: reset=1 while match_lock=1 -> all outputs at their reset values the next cycle, and lock_lost stays 0.
